// File: rtl/sc_config_latch_pkg.sv
// Shared types and constants for the frame-synchronous config latch.
package sc_config_pkg;

  localparam int unsigned CFG_WORD_W = 32;

  localparam int unsigned STATUS_W       = 32;
  localparam int unsigned STAT_PENDING   = 0;
  localparam int unsigned STAT_TIMEOUT   = 1;
  localparam int unsigned STAT_FRAMECNT  = 8;
  localparam int unsigned FRAMECNT_W     = 8;
  localparam int unsigned STAT_COMMITCNT = 16;
  localparam int unsigned COMMITCNT_W    = 16;

  typedef enum logic {
    IDLE  = 1'b0,
    ARMED = 1'b1
  } state_e;

endpackage

// File: rtl/sc_config_latch_if.sv
// Staged-config / applied-config bundle between the config block and the latch.
interface sc_config_latch_if
  import sc_config_pkg::*;
#(
  parameter int unsigned NUM_WORDS = 12
);

  logic [NUM_WORDS*CFG_WORD_W-1:0] cfg_i;
  logic                            commit_req_i;
  logic                            bypass_i;
  logic                            vsync_i;
  logic [NUM_WORDS*CFG_WORD_W-1:0] cfg_o;
  logic                            commit_pending_o;
  logic                            commit_done_o;
  logic [STATUS_W-1:0]             status_o;

  modport slave (
    input  cfg_i, commit_req_i, bypass_i, vsync_i,
    output cfg_o, commit_pending_o, commit_done_o, status_o
  );

  modport master (
    output cfg_i, commit_req_i, bypass_i, vsync_i,
    input  cfg_o, commit_pending_o, commit_done_o, status_o
  );

endinterface

// File: rtl/sc_config_latch_edge_det.sv
// Registered rising-edge detector; edge output is combinational from the input.
module sc_edge_det (
  input  logic clk_i,
  input  logic rst_i,
  input  logic d_i,
  output logic edge_c_o
);

  logic d_q, d_d;
  logic live_q, live_d;

  always_comb begin
    d_d    = d_i;
    live_d = 1'b1;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      d_q    <= 1'b0;
      live_q <= 1'b0;
    end else begin
      d_q    <= d_d;
      live_q <= live_d;
    end
  end

  // The first cycle out of reset only primes d_q, so a level held through reset is not an edge.
  assign edge_c_o = live_q & d_i & ~d_q;

endmodule

// File: rtl/sc_config_latch.sv
// Double-buffers the video-timing config words and applies them atomically on a
// vsync leading edge, with a timeout-forced commit and a transparent bypass mode.
module sc_config_latch
  import sc_config_pkg::*;
#(
  parameter int unsigned NUM_WORDS      = 12,
  parameter int unsigned TIMEOUT_CYCLES = 2700000
) (
  input logic               clk_i,
  input logic               rst_i,
  sc_config_latch_if.slave  bus
);

  localparam int unsigned CFG_W = NUM_WORDS * CFG_WORD_W;
  localparam int unsigned CNT_W = $clog2(TIMEOUT_CYCLES);

  logic req_edge_c;
  logic vs_edge_c;

  state_e                 state_q, state_d;
  logic [CNT_W-1:0]       cnt_q, cnt_d;
  logic [CFG_W-1:0]       cfg_q, cfg_d;
  logic                   done_q, done_d;
  logic                   timeout_q, timeout_d;
  logic                   bypass_q, bypass_d;
  logic [FRAMECNT_W-1:0]  frame_q, frame_d;
  logic [COMMITCNT_W-1:0] commit_cnt_q, commit_cnt_d;
  logic [STATUS_W-1:0]    status;

  sc_edge_det u_req_det (
    .clk_i    (clk_i),
    .rst_i    (rst_i),
    .d_i      (bus.commit_req_i),
    .edge_c_o (req_edge_c)
  );

  sc_edge_det u_vs_det (
    .clk_i    (clk_i),
    .rst_i    (rst_i),
    .d_i      (bus.vsync_i),
    .edge_c_o (vs_edge_c)
  );

  // Next-state and datapath update.
  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    cfg_d        = cfg_q;
    done_d       = 1'b0;
    timeout_d    = timeout_q;
    bypass_d     = bus.bypass_i;
    frame_d      = frame_q;
    commit_cnt_d = commit_cnt_q;

    if (vs_edge_c) frame_d = frame_q + FRAMECNT_W'(1);

    if (bus.bypass_i) begin
      state_d = IDLE;
      cnt_d   = '0;
      cfg_d   = bus.cfg_i;
      if (!bypass_q) begin
        done_d       = 1'b1;
        timeout_d    = 1'b0;
        commit_cnt_d = commit_cnt_q + COMMITCNT_W'(1);
      end
    end else begin
      unique case (state_q)
        IDLE: begin
          // A vsync edge coinciding with the arming edge belongs to the old frame.
          if (req_edge_c) begin
            state_d = ARMED;
            cnt_d   = '0;
          end
        end
        ARMED: begin
          cnt_d = cnt_q + CNT_W'(1);
          if (vs_edge_c || (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1))) begin
            state_d      = IDLE;
            cnt_d        = '0;
            cfg_d        = bus.cfg_i;
            done_d       = 1'b1;
            timeout_d    = ~vs_edge_c;
            commit_cnt_d = commit_cnt_q + COMMITCNT_W'(1);
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q      <= IDLE;
      cnt_q        <= '0;
      cfg_q        <= '0;
      done_q       <= 1'b0;
      timeout_q    <= 1'b0;
      bypass_q     <= 1'b0;
      frame_q      <= '0;
      commit_cnt_q <= '0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      cfg_q        <= cfg_d;
      done_q       <= done_d;
      timeout_q    <= timeout_d;
      bypass_q     <= bypass_d;
      frame_q      <= frame_d;
      commit_cnt_q <= commit_cnt_d;
    end
  end

  // Status word assembled purely from flops.
  always_comb begin
    status                                    = '0;
    status[STAT_PENDING]                      = (state_q == ARMED);
    status[STAT_TIMEOUT]                      = timeout_q;
    status[STAT_FRAMECNT +: FRAMECNT_W]       = frame_q;
    status[STAT_COMMITCNT +: COMMITCNT_W]     = commit_cnt_q;
  end

  assign bus.cfg_o            = cfg_q;
  assign bus.commit_pending_o = (state_q == ARMED);
  assign bus.commit_done_o    = done_q;
  assign bus.status_o         = status;

endmodule

// File: tb/tb_sc_config_latch.sv
// Directed, table-driven bench for sc_config_latch with a short timeout.
module tb_sc_config_latch;
  import sc_config_pkg::*;

  localparam int unsigned NW = 12;
  localparam int unsigned TO = 16;
  localparam int unsigned NV = 17;

  logic clk = 1'b0;
  logic rst;
  int unsigned n_tests = 0;
  int unsigned n_fail  = 0;

  always #5 clk = ~clk;

  sc_config_latch_if #(.NUM_WORDS(NW)) bus ();

  sc_config_latch #(
    .NUM_WORDS      (NW),
    .TIMEOUT_CYCLES (TO)
  ) u_dut (
    .clk_i (clk),
    .rst_i (rst),
    .bus   (bus.slave)
  );

  typedef struct {
    logic        rst;
    logic        req;
    logic        vs;
    logic        byp;
    logic [31:0] word;
    logic [31:0] exp_cfg;
    logic        exp_done;
    logic        exp_pend;
    logic [31:0] exp_status;
  } vec_t;

  vec_t vecs [NV];

  function automatic vec_t mk(input logic r, input logic q, input logic v, input logic b,
                              input logic [31:0] w, input logic [31:0] ec, input logic ed,
                              input logic ep, input logic [31:0] es);
    vec_t t;
    t.rst = r; t.req = q; t.vs = v; t.byp = b; t.word = w;
    t.exp_cfg = ec; t.exp_done = ed; t.exp_pend = ep; t.exp_status = es;
    return t;
  endfunction

  function automatic logic [NW*32-1:0] rep(input logic [31:0] w);
    logic [NW*32-1:0] r;
    for (int i = 0; i < int'(NW); i++) r[i*32 +: 32] = w;
    return r;
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic r, input logic q, input logic v, input logic b,
                       input logic [31:0] w);
    rst              = r;
    bus.commit_req_i = q;
    bus.vsync_i      = v;
    bus.bypass_i     = b;
    bus.cfg_i        = rep(w);
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic chk_cfg(input string name, input logic [31:0] w);
    int bad;
    logic [31:0] got;
    bad = -1;
    got = '0;
    for (int i = int'(NW) - 1; i >= 0; i--) begin
      if (bus.cfg_o[i*32 +: 32] !== w) begin
        bad = i;
        got = bus.cfg_o[i*32 +: 32];
      end
    end
    n_tests++;
    if (bad >= 0) begin
      n_fail++;
      $display("FAIL %s: cfg word %0d got 0x%08h expected 0x%08h", name, bad, got, w);
    end
  endtask

  task automatic chk_all(input string name, input logic [31:0] ec, input logic ed,
                         input logic ep, input logic [31:0] es);
    chk_cfg({name, ".cfg"}, ec);
    chk({name, ".done"}, 32'(bus.commit_done_o), 32'(ed));
    chk({name, ".pend"}, 32'(bus.commit_pending_o), 32'(ep));
    chk({name, ".status"}, bus.status_o, es);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    // reset, idle vsyncs, normal commit, same-cycle req+vsync
    vecs[0]  = mk(1, 0, 0, 0, 32'hA5A5A5A5, 32'h0,        0, 0, 32'h0000_0000);
    vecs[1]  = mk(1, 0, 0, 0, 32'hA5A5A5A5, 32'h0,        0, 0, 32'h0000_0000);
    vecs[2]  = mk(0, 0, 0, 0, 32'hA5A5A5A5, 32'h0,        0, 0, 32'h0000_0000);
    vecs[3]  = mk(0, 0, 1, 0, 32'hA5A5A5A5, 32'h0,        0, 0, 32'h0000_0100);
    vecs[4]  = mk(0, 0, 0, 0, 32'hA5A5A5A5, 32'h0,        0, 0, 32'h0000_0100);
    vecs[5]  = mk(0, 0, 1, 0, 32'hA5A5A5A5, 32'h0,        0, 0, 32'h0000_0200);
    vecs[6]  = mk(0, 0, 0, 0, 32'hA5A5A5A5, 32'h0,        0, 0, 32'h0000_0200);
    vecs[7]  = mk(0, 0, 1, 0, 32'hA5A5A5A5, 32'h0,        0, 0, 32'h0000_0300);
    vecs[8]  = mk(0, 0, 0, 0, 32'hA5A5A5A5, 32'h0,        0, 0, 32'h0000_0300);
    vecs[9]  = mk(0, 1, 0, 0, 32'hA5A5A5A5, 32'h0,        0, 1, 32'h0000_0301);
    vecs[10] = mk(0, 0, 0, 0, 32'h12345678, 32'h0,        0, 1, 32'h0000_0301);
    vecs[11] = mk(0, 0, 1, 0, 32'h12345678, 32'h12345678, 1, 0, 32'h0001_0400);
    vecs[12] = mk(0, 0, 0, 0, 32'hDEADBEEF, 32'h12345678, 0, 0, 32'h0001_0400);
    vecs[13] = mk(0, 1, 1, 0, 32'h11111111, 32'h12345678, 0, 1, 32'h0001_0501);
    vecs[14] = mk(0, 0, 0, 0, 32'h22222222, 32'h12345678, 0, 1, 32'h0001_0501);
    vecs[15] = mk(0, 0, 1, 0, 32'h33333333, 32'h33333333, 1, 0, 32'h0002_0600);
    vecs[16] = mk(0, 0, 0, 0, 32'h44444444, 32'h33333333, 0, 0, 32'h0002_0600);

    drive(1, 0, 0, 0, 32'hA5A5A5A5);
    for (int i = 0; i < int'(NV); i++) begin
      drive(vecs[i].rst, vecs[i].req, vecs[i].vs, vecs[i].byp, vecs[i].word);
      step();
      chk_all($sformatf("vec%0d", i), vecs[i].exp_cfg, vecs[i].exp_done,
              vecs[i].exp_pend, vecs[i].exp_status);
    end

    // Timeout-forced commit; a second request mid-wait must not extend it.
    drive(0, 1, 0, 0, 32'hCAFE0000);
    step();
    chk("to.arm.pend", 32'(bus.commit_pending_o), 32'd1);
    for (int k = 1; k <= int'(TO); k++) begin
      drive(0, (k == 6), 0, 0, 32'hCAFE0000 + 32'(k));
      step();
      if (k < int'(TO)) begin
        chk($sformatf("to.wait%0d.done", k), 32'(bus.commit_done_o), 32'd0);
        chk($sformatf("to.wait%0d.pend", k), 32'(bus.commit_pending_o), 32'd1);
      end else begin
        chk_all("to.fire", 32'hCAFE0010, 1, 0, 32'h0003_0602);
      end
    end
    drive(0, 0, 0, 0, 32'h0);
    step();
    chk_all("to.after", 32'hCAFE0010, 0, 0, 32'h0003_0602);

    // Normal commit clears the timeout flag.
    drive(0, 1, 0, 0, 32'h0);
    step();
    drive(0, 0, 1, 0, 32'h5555AAAA);
    step();
    chk_all("clr.commit", 32'h5555AAAA, 1, 0, 32'h0004_0700);
    drive(0, 0, 0, 0, 32'h0);
    step();
    chk("clr.done_low", 32'(bus.commit_done_o), 32'd0);

    // Reset while armed, then a request level held through reset.
    drive(0, 1, 0, 0, 32'h0BADF00D);
    step();
    chk("rst.arm.pend", 32'(bus.commit_pending_o), 32'd1);
    step();
    drive(1, 1, 0, 0, 32'h0BADF00D);
    step();
    chk_all("rst.hit", 32'h0, 0, 0, 32'h0);
    drive(0, 1, 0, 0, 32'h0BADF00D);
    step();
    step();
    chk_all("rst.held", 32'h0, 0, 0, 32'h0);
    drive(0, 1, 1, 0, 32'h0BADF00D);
    step();
    chk_all("rst.vs", 32'h0, 0, 0, 32'h0000_0100);
    drive(0, 0, 0, 0, 32'h0);
    step();
    chk_all("rst.vs_low", 32'h0, 0, 0, 32'h0000_0100);

    // Bypass entered from ARMED: follows cfg_i with one cycle latency.
    drive(0, 1, 0, 0, 32'h0);
    step();
    chk("byp.arm.status", bus.status_o, 32'h0000_0101);
    for (int k = 0; k < 8; k++) begin
      drive(0, 0, 0, 1, 32'hB0000000 + 32'(k));
      step();
      chk_cfg($sformatf("byp%0d.cfg", k), 32'hB0000000 + 32'(k));
      chk($sformatf("byp%0d.done", k), 32'(bus.commit_done_o), 32'(k == 0));
    end
    chk("byp.status", bus.status_o, 32'h0001_0100);
    drive(0, 0, 0, 0, 32'hFFFFFFFF);
    step();
    chk_all("byp.exit", 32'hB0000007, 0, 0, 32'h0001_0100);
    step();
    chk_cfg("byp.hold", 32'hB0000007);

    // Frame counter wraps after 256 vsync edges.
    for (int i = 1; i <= 256; i++) begin
      drive(0, 0, 1, 0, 32'h0);
      step();
      if (i == 255) chk("frame.wrap", 32'(bus.status_o[15:8]), 32'h0);
      drive(0, 0, 0, 0, 32'h0);
      step();
    end
    chk("frame.final", bus.status_o, 32'h0001_0100);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
